// File: rtl/rgb_led_controller.sv
// RGB LED controller for the whack-a-mole game.
// A mode register (stage p0) decodes the game state and hit/miss strobes;
// an output register (stage p1) turns the mode into per-colour PWM levels.
// All LEDs of one colour always carry the same value.
module rgb_led_controller #(
  parameter int NUM_LEDS   = 3,
  parameter int PWM_BITS   = 8,
  parameter int DIM_DUTY   = 32,
  parameter int BLINK_HALF = 25_000_000,
  parameter int FLASH_LEN  = 5_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          state,
  input  logic                hit_pulse,
  input  logic                miss_pulse,
  output logic [NUM_LEDS-1:0] led_red,
  output logic [NUM_LEDS-1:0] led_green,
  output logic [NUM_LEDS-1:0] led_blue
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int FW = $clog2(FLASH_LEN + 1);

  localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;
  localparam logic [PWM_BITS-1:0] DUTY_OFF  = '0;
  localparam logic [PWM_BITS-1:0] DUTY_DIM  = PWM_BITS'(DIM_DUTY);
  localparam logic [BW-1:0]       BLINK_END = BW'(BLINK_HALF - 1);
  localparam logic [FW-1:0]       FLASH_RLD = FW'(FLASH_LEN);
  localparam logic [FW-1:0]       FLASH_ONE = FW'(1);

  typedef enum logic [2:0] {
    M_OFF,
    M_PLAY,
    M_FLASH_HIT,
    M_FLASH_MISS,
    M_OVER,
    M_CLEAR
  } mode_t;

  mode_t                mode_p0;
  mode_t                mode_nxt;
  logic                 flash_load;
  logic [FW-1:0]        flash_cnt_p0;
  logic [BW-1:0]        blink_cnt_p0;
  logic                 blink_off_p0;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [PWM_BITS-1:0]  duty_r;
  logic [PWM_BITS-1:0]  duty_g;
  logic [PWM_BITS-1:0]  duty_b;
  logic                 in_flash;

  // Full duty means constantly on, so the compare alone would miss the top count.
  function automatic logic pwm_on(input logic [PWM_BITS-1:0] cnt,
                                  input logic [PWM_BITS-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

  assign in_flash = (mode_p0 == M_FLASH_HIT) || (mode_p0 == M_FLASH_MISS);

  // Free-running PWM counter shared by every channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Next-mode decode: OVER/CLEAR dominate, flashes only start from PLAY or a flash.
  always_comb begin
    mode_nxt   = M_OFF;
    flash_load = 1'b0;
    case (state)
      3'd3: mode_nxt = M_OVER;
      3'd5: mode_nxt = M_CLEAR;
      3'd2: begin
        if ((mode_p0 == M_PLAY || in_flash) && miss_pulse) begin
          mode_nxt   = M_FLASH_MISS;
          flash_load = 1'b1;
        end else if ((mode_p0 == M_PLAY || in_flash) && hit_pulse) begin
          mode_nxt   = M_FLASH_HIT;
          flash_load = 1'b1;
        end else if (in_flash && flash_cnt_p0 > FLASH_ONE) begin
          mode_nxt   = mode_p0;
        end else begin
          mode_nxt   = M_PLAY;
        end
      end
      default: mode_nxt = M_OFF;
    endcase
  end

  // ---- stage p0: mode register and its flash/blink timers ----
  // Mode register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_p0 <= M_OFF;
    else     mode_p0 <= mode_nxt;
  end

  // Flash timer: reloaded by every accepted pulse, counts down while flashing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     flash_cnt_p0 <= '0;
    else if (flash_load)                         flash_cnt_p0 <= FLASH_RLD;
    else if (in_flash && flash_cnt_p0 != '0)     flash_cnt_p0 <= flash_cnt_p0 - 1'b1;
    else                                         flash_cnt_p0 <= '0;
  end

  // Blink timer: held cleared outside CLEAR so every entry starts with an on half-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_p0 <= '0;
      blink_off_p0 <= 1'b0;
    end else if (mode_p0 != M_CLEAR) begin
      blink_cnt_p0 <= '0;
      blink_off_p0 <= 1'b0;
    end else if (blink_cnt_p0 == BLINK_END) begin
      blink_cnt_p0 <= '0;
      blink_off_p0 <= ~blink_off_p0;
    end else begin
      blink_cnt_p0 <= blink_cnt_p0 + 1'b1;
    end
  end

  // Per-colour duty selected by the current mode.
  always_comb begin
    duty_r = DUTY_OFF;
    duty_g = DUTY_OFF;
    duty_b = DUTY_OFF;
    case (mode_p0)
      M_PLAY:       duty_b = DUTY_DIM;
      M_FLASH_HIT:  duty_g = DUTY_FULL;
      M_FLASH_MISS: duty_r = DUTY_FULL;
      M_OVER:       duty_r = DUTY_FULL;
      M_CLEAR:      duty_g = blink_off_p0 ? DUTY_OFF : DUTY_FULL;
      default: ;
    endcase
  end

  // ---- stage p1: registered LED drive ----
  // Output register, one PWM decision replicated across all LEDs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_red   <= '0;
      led_green <= '0;
      led_blue  <= '0;
    end else begin
      led_red   <= {NUM_LEDS{pwm_on(pwm_cnt, duty_r)}};
      led_green <= {NUM_LEDS{pwm_on(pwm_cnt, duty_g)}};
      led_blue  <= {NUM_LEDS{pwm_on(pwm_cnt, duty_b)}};
    end
  end

endmodule

// File: tb/tb_rgb_led_controller.sv
// Self-checking bench for rgb_led_controller with small timing parameters.
// A reference model predicts each output edge and queues it; the checker pops
// and compares at the falling edge.
module tb_rgb_led_controller;

  localparam int NL = 3;
  localparam int PB = 4;
  localparam int DD = 4;
  localparam int BH = 8;
  localparam int FL = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    state = 3'd0;
  logic          hit_pulse = 1'b0;
  logic          miss_pulse = 1'b0;
  logic [NL-1:0] led_red;
  logic [NL-1:0] led_green;
  logic [NL-1:0] led_blue;

  int nchk = 0;
  int nerr = 0;

  logic [8:0] sb[$];

  rgb_led_controller #(
    .NUM_LEDS(NL), .PWM_BITS(PB), .DIM_DUTY(DD), .BLINK_HALF(BH), .FLASH_LEN(FL)
  ) dut (
    .clk(clk), .rst(rst), .state(state), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .led_red(led_red), .led_green(led_green),
    .led_blue(led_blue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. Modes: 0 OFF, 1 PLAY, 2 HIT, 3 MISS, 4 OVER, 5 CLEAR.
  int m_mode = 0;
  int m_pwm  = 0;
  int m_age  = 0;
  int m_left = 0;

  always @(posedge clk) begin
    int nm;
    logic [2:0] er, eg, eb;
    if (rst) begin
      m_mode = 0; m_pwm = 0; m_age = 0; m_left = 0;
      sb.delete();
    end else begin
      er = 3'b000; eg = 3'b000; eb = 3'b000;
      case (m_mode)
        1: eb = (m_pwm < DD) ? 3'b111 : 3'b000;
        2: eg = 3'b111;
        3: er = 3'b111;
        4: er = 3'b111;
        5: eg = (((m_age / BH) % 2) == 0) ? 3'b111 : 3'b000;
        default: ;
      endcase
      sb.push_back({er, eg, eb});
      m_pwm = (m_pwm + 1) % (1 << PB);
      if (state == 3'd3) nm = 4;
      else if (state == 3'd5) nm = 5;
      else if (state == 3'd2) begin
        if (m_mode >= 1 && m_mode <= 3 && (miss_pulse || hit_pulse)) begin
          nm = miss_pulse ? 3 : 2;
          m_left = FL;
        end else if ((m_mode == 2 || m_mode == 3) && m_left > 1) begin
          nm = m_mode;
          m_left = m_left - 1;
        end else nm = 1;
      end else nm = 0;
      if (nm != 2 && nm != 3) m_left = 0;
      if (nm == 5 && m_mode == 5) m_age = m_age + 1;
      else m_age = 0;
      m_mode = nm;
    end
  end

  // Scoreboard checker; while reset is high the outputs must be all zero.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      sb.delete();
      chk("rst_red", led_red, 0);
      chk("rst_green", led_green, 0);
      chk("rst_blue", led_blue, 0);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("red", led_red, e[8:6]);
      chk("green", led_green, e[5:3]);
      chk("blue", led_blue, e[2:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic h, input logic m);
    hit_pulse = h;
    miss_pulse = m;
    tick();
    hit_pulse = 1'b0;
    miss_pulse = 1'b0;
  endtask

  initial begin
    int cnt;
    ticks(3);
    rst = 1'b0;
    ticks(4);

    // Game over: solid red.
    state = 3'd3;
    ticks(10);

    // Game clear: green blink.
    state = 3'd5;
    ticks(40);

    // Play: dim blue, 4 of every 16 cycles.
    state = 3'd2;
    ticks(2);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (led_blue == 3'b111) cnt++;
    end
    chk("blue_duty_count", cnt, 8);
    tick();

    // Simultaneous strobes: miss wins; then a hit three cycles in re-colours.
    pulse(1'b1, 1'b1);
    ticks(10);
    pulse(1'b1, 1'b1);
    ticks(2);
    pulse(1'b1, 1'b0);
    ticks(10);

    // State leaves PLAY mid-flash: flash is dropped.
    pulse(1'b1, 1'b0);
    ticks(2);
    state = 3'd3;
    ticks(3);
    state = 3'd2;
    ticks(10);

    // Pulses outside PLAY are ignored.
    state = 3'd0;
    ticks(2);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    state = 3'd2;
    ticks(6);

    // Reset in the middle of a blink.
    state = 3'd5;
    ticks(12);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_red", led_red, 0);
    chk("async_rst_green", led_green, 0);
    chk("async_rst_blue", led_blue, 0);
    ticks(2);
    rst = 1'b0;
    ticks(2);
    cnt = 0;
    for (int i = 0; i < BH; i++) begin
      @(negedge clk);
      if (led_green == 3'b111) cnt++;
    end
    chk("green_after_rst", cnt, BH);
    @(negedge clk);
    chk("green_off_phase", led_green, 0);
    tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 7))
          0: state = 3'd0;
          1: state = 3'd1;
          2, 3, 4: state = 3'd2;
          5: state = 3'd3;
          6: state = 3'd5;
          default: state = 3'd7;
        endcase
      end
      hit_pulse  = ($urandom_range(0, 5) == 0);
      miss_pulse = ($urandom_range(0, 6) == 0);
      tick();
    end
    hit_pulse = 1'b0;
    miss_pulse = 1'b0;
    ticks(3);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
